// File: rtl/snn_layer_sequencer.sv
// Walks one SNN inference through NUM_LAYERS layers: one-cycle start pulse per layer,
// wait for that layer's done (with watchdog), then report completion and cycle count.
module snn_layer_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CYC_W          = 16,
  localparam int LIDX_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  infer_start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [LIDX_W-1:0]     layer_idx,
  output logic                  busy,
  output logic                  infer_done,
  output logic                  timeout_err,
  output logic [CYC_W-1:0]      infer_cycles
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FINISH, ERROR} state_t;

  state_t          state;
  logic [WD_W-1:0] wd;
  logic            done_sel;

  // Select the awaited layer's done by compare rather than a variable bit-select,
  // so the index width never has to match the vector width.
  always_comb begin
    done_sel = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (layer_idx == LIDX_W'(i)) done_sel = layer_done[i];
  end

  always_comb begin
    layer_start = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (state == ISSUE && layer_idx == LIDX_W'(i)) layer_start[i] = 1'b1;
  end

  assign busy       = (state == ISSUE) || (state == WAIT) || (state == FINISH);
  assign infer_done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      layer_idx    <= '0;
      timeout_err  <= 1'b0;
      infer_cycles <= '0;
      wd           <= '0;
    end else if (abort) begin
      state       <= IDLE;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (infer_start) begin
          layer_idx    <= '0;
          infer_cycles <= '0;
          state        <= ISSUE;
        end
        ISSUE: begin
          wd <= '0;
          if (infer_cycles != {CYC_W{1'b1}}) infer_cycles <= infer_cycles + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + 1'b1;
          if (infer_cycles != {CYC_W{1'b1}}) infer_cycles <= infer_cycles + 1'b1;
          // wd==0 blanks a done level left over from the previous inference
          if (wd != '0 && done_sel) begin
            if (layer_idx == LAST_IDX) state <= FINISH;
            else begin
              layer_idx <= layer_idx + 1'b1;
              state     <= ISSUE;
            end
          end else if (wd == WD_LAST) begin
            timeout_err <= 1'b1;
            state       <= ERROR;
          end
        end
        FINISH:  state <= IDLE;
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Scoreboarded bench: a per-layer responder drives done after a chosen delay, a
// reference model predicts start/done/timeout events, and a monitor checks them.
module tb_snn_layer_sequencer;
  localparam int NL = 3;
  localparam int T  = 256;

  logic          clk = 1'b0, reset = 1'b1, infer_start = 1'b0, abort = 1'b0;
  logic [NL-1:0] layer_done = '0;
  logic [NL-1:0] layer_start;
  logic [1:0]    layer_idx;
  logic          busy, infer_done, timeout_err;
  logic [15:0]   infer_cycles;

  logic          s_start = 1'b0;
  logic [0:0]    s_done = 1'b0;
  logic [0:0]    s_lstart;
  logic [0:0]    s_idx;
  logic          s_busy, s_idone, s_to;
  logic [3:0]    s_cyc;

  snn_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(T), .CYC_W(16)) dut (
    .clk(clk), .reset(reset), .infer_start(infer_start), .abort(abort),
    .layer_done(layer_done), .layer_start(layer_start), .layer_idx(layer_idx),
    .busy(busy), .infer_done(infer_done), .timeout_err(timeout_err),
    .infer_cycles(infer_cycles));

  snn_layer_sequencer #(.NUM_LAYERS(1), .TIMEOUT_CYCLES(32), .CYC_W(4)) dut1 (
    .clk(clk), .reset(reset), .infer_start(s_start), .abort(1'b0),
    .layer_done(s_done), .layer_start(s_lstart), .layer_idx(s_idx),
    .busy(s_busy), .infer_done(s_idone), .timeout_err(s_to),
    .infer_cycles(s_cyc));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // kind: 0 = layer start, 1 = inference done, 2 = timeout
  typedef struct {int kind; int l; int c; int cy;} ev_t;
  ev_t q[$];

  int dly[NL];
  bit noise = 1'b0;

  // Reference model: layer l's done qualifies dly[l] cycles after its start, so the
  // layer costs 1+dly[l] cycles; a layer whose done comes later than T times out.
  task automatic expect_run(input int k);
    int t, acc;
    t = k + 1; acc = 0;
    for (int l = 0; l < NL; l++) begin
      q.push_back('{0, l, t, acc});
      if (dly[l] > T) begin
        q.push_back('{2, l, t + T + 1, acc + 1 + T});
        return;
      end
      acc += 1 + dly[l];
      t   += dly[l] + 1;
    end
    q.push_back('{1, NL - 1, t, acc});
  endtask

  // Responder: the active layer keeps its old done level through the first WAIT
  // cycle (stale done), then reports done from start+dly onward and holds it.
  int act = -1, st_cyc = 0;
  always @(negedge clk) begin
    for (int l = 0; l < NL; l++)
      if (layer_start[l]) begin act = l; st_cyc = cyc; end
    for (int l = 0; l < NL; l++) begin
      if (l == act) begin
        if (cyc >= st_cyc + 2) layer_done[l] = (cyc >= st_cyc + dly[l]);
      end else if (noise) layer_done[l] = 1'($urandom_range(0, 1));
    end
  end

  task automatic take(input int kind, input string nm);
    ev_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_%s: got event expected none (cycle %0d)", nm, cyc);
      return;
    end
    e = q.pop_front();
    chk({nm, "_kind"}, kind, e.kind);
    chk({nm, "_cycle"}, cyc, e.c);
    chk({nm, "_cycles_cnt"}, int'(infer_cycles), e.cy);
    if (kind == 0) chk("start_onehot", int'(layer_start), 1 << e.l);
    if (kind != 2) chk({nm, "_idx"}, int'(layer_idx), e.l);
    if (kind == 1) chk("done_busy", int'(busy), 1);
  endtask

  logic prev_to = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (layer_start != '0)        take(0, "start");
      if (infer_done)               take(1, "done");
      if (timeout_err && !prev_to)  take(2, "timeout");
    end
    prev_to = timeout_err;
  end

  task automatic start_run();
    @(negedge clk);
    expect_run(cyc);
    infer_start = 1'b1;
    @(negedge clk);
    infer_start = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    for (int i = 0; i < lim && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d events outstanding expected 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_layer(input int l, input int lim);
    int i;
    for (i = 0; i < lim && !(busy && int'(layer_idx) == l); i++) @(negedge clk);
    if (i == lim) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_layer%0d: got timeout expected layer reached", l);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int held, k, nst, ndn;
    dly = '{5, 5, 5};
    repeat (3) @(negedge clk);
    chk("rst_start", int'(layer_start), 0);
    chk("rst_idx", int'(layer_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(infer_done), 0);
    chk("rst_to", int'(timeout_err), 0);
    chk("rst_cycles", int'(infer_cycles), 0);
    chk("rst_small", int'({s_lstart, s_idx, s_busy, s_idone, s_to, s_cyc}), 0);
    reset = 1'b0;

    // basic run, then the same run again with all done bits still high (stale)
    repeat (2) begin
      dly = '{5, 5, 5};
      start_run();
      wait_drain(100);
      chk("busy_after", int'(busy), 0);
    end

    // random delays, random activity on the non-awaited done bits
    for (int r = 0; r < 8; r++) begin
      noise = 1'($urandom_range(0, 1));
      for (int l = 0; l < NL; l++) dly[l] = $urandom_range(2, 12);
      start_run();
      wait_drain(200);
    end

    // done on the last watchdog cycle wins over timeout
    noise = 1'b1;
    dly = '{3, T, 2};
    start_run();
    wait_drain(400);
    chk("edge_to", int'(timeout_err), 0);

    // layer 1 never finishes
    noise = 1'b0;
    dly = '{3, 300, 3};
    start_run();
    wait_drain(400);
    chk("err_busy", int'(busy), 0);
    chk("err_to", int'(timeout_err), 1);
    @(negedge clk); infer_start = 1'b1;
    @(negedge clk); infer_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_ignore_to", int'(timeout_err), 1);
    chk("err_ignore_busy", int'(busy), 0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_clr_to", int'(timeout_err), 0);
    chk("abort_clr_busy", int'(busy), 0);

    // abort mid-WAIT on layer 1 together with infer_start
    dly = '{4, 50, 4};
    start_run();
    wait_layer(1, 100);
    repeat (10) @(negedge clk);
    held = int'(infer_cycles);
    q.delete();
    abort = 1'b1; infer_start = 1'b1;
    @(negedge clk);
    abort = 1'b0; infer_start = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_hold_cycles", int'(infer_cycles), held);
    repeat (5) @(negedge clk);
    chk("abort_no_done", int'(infer_done), 0);
    dly = '{2, 7, 3};
    start_run();
    wait_drain(100);

    // reset during WAIT of layer 2
    dly = '{3, 3, 40};
    start_run();
    wait_layer(2, 100);
    repeat (5) @(negedge clk);
    q.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_start", int'(layer_start), 0);
    chk("rst2_idx", int'(layer_idx), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_done", int'(infer_done), 0);
    chk("rst2_to", int'(timeout_err), 0);
    chk("rst2_cycles", int'(infer_cycles), 0);
    repeat (3) @(negedge clk);

    // single-layer instance; 21 cycles saturate its 4-bit counter at 15
    @(negedge clk); s_start = 1'b1; k = cyc;
    @(negedge clk); s_start = 1'b0;
    nst = 0; ndn = 0;
    for (int i = 0; i < 60; i++) begin
      if (cyc == k + 21) s_done = 1'b1;
      if (s_lstart[0]) begin
        nst++;
        chk("one_start_cycle", cyc, k + 1);
        chk("one_idx", int'(s_idx), 0);
      end
      if (s_idone) begin
        ndn++;
        chk("one_done_cycle", cyc, k + 22);
        chk("one_sat_cycles", int'(s_cyc), 15);
      end
      @(negedge clk);
    end
    chk("one_nstart", nst, 1);
    chk("one_ndone", ndn, 1);
    chk("one_to", int'(s_to), 0);

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
